// File: rtl/boa_intc_pkg.sv
// Shared constants, mode encoding and claim helper for the boa32 interrupt controller.
package boa_intc_pkg;

  localparam int INTC_MAX_CHANNELS = 32;

  localparam logic [4:0] INTC_PENDING  = 5'h00;
  localparam logic [4:0] INTC_ENABLE   = 5'h04;
  localparam logic [4:0] INTC_MODE     = 5'h08;
  localparam logic [4:0] INTC_POLARITY = 5'h0C;
  localparam logic [4:0] INTC_CLAIM    = 5'h10;
  localparam logic [4:0] INTC_RAW      = 5'h14;

  typedef enum logic {
    INTC_LEVEL = 1'b0,
    INTC_EDGE  = 1'b1
  } intc_mode_t;

  // Index+1 of the lowest set bit, 0 when nothing is active.
  function automatic logic [31:0] intc_claim_id(input logic [31:0] act);
    logic [31:0] id;
    id = 32'd0;
    for (int i = INTC_MAX_CHANNELS - 1; i >= 0; i--) begin
      if (act[i]) begin
        id = 32'(i + 1);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Simple single-cycle-request peripheral bus used on the boa32 peripheral mux.
interface boa_mem_bus;
  logic [31:0] addr;
  logic [3:0]  we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input addr, input we, input re, input wdata, output rdata, output ready);
  modport CPU (output addr, output we, output re, output wdata, input rdata, input ready);
endinterface

// File: rtl/boa_intc_sync_edge.sv
// Per-channel input synchroniser, polarity correction and rising-edge detector.
module boa_intc_sync_edge #(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_pol,
  output logic o_sync,
  output logic o_s,
  output logic o_rise
);

  logic w_sync;
  logic w_s;
  logic r_prev;

  if (sync_stages == 0) begin : g_bypass
    assign w_sync = i_raw;
  end else begin : g_sync
    logic [sync_stages-1:0] r_sync;

    // Metastability chain toward the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= i_raw;
        for (int k = 1; k < sync_stages; k++) begin
          r_sync[k] <= r_sync[k-1];
        end
      end
    end

    assign w_sync = r_sync[sync_stages-1];
  end

  assign w_s = w_sync ^ i_pol;

  // Previous value of the polarity-corrected input, armed at 0 from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_s;
    end
  end

  assign o_sync = w_sync;
  assign o_s    = w_s;
  assign o_rise = w_s & ~r_prev;

endmodule

// File: rtl/boa_peri_intc.sv
// boa32 interrupt controller: per-channel level/edge sources, pending/enable
// registers and a lowest-index claim register on the peripheral bus.
module boa_peri_intc
  import boa_intc_pkg::*;
#(
  parameter int channels    = 14,
  parameter int sync_stages = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  boa_mem_bus.MEM             bus,
  input  logic [channels-1:0] irq_in,
  output logic [channels-1:0] irq_out,
  output logic                irq_any
);

  logic [channels-1:0] r_pending, r_enable, r_mode, r_polarity;
  logic [channels-1:0] r_irq_out;
  logic                r_irq_any;
  logic                r_ready;
  logic [31:0]         r_rdata;

  logic [channels-1:0] w_raw, w_s, w_rise;
  logic [31:0]         w_bmask;
  logic [channels-1:0] w_wr_mask, w_wr_bits;
  logic [4:0]          w_off;
  logic                w_wr_any, w_claim_rd;
  logic [31:0]         w_claim_id;
  logic [channels-1:0] w_claim_clr, w_clr, w_mode_fall, w_pending_nxt;
  logic [31:0]         w_rd_data;

  for (genvar g = 0; g < channels; g++) begin : g_ch
    boa_intc_sync_edge #(.sync_stages(sync_stages)) u_sync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (irq_in[g]),
      .i_pol  (r_polarity[g]),
      .o_sync (w_raw[g]),
      .o_s    (w_s[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_bmask    = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
  assign w_wr_mask  = w_bmask[channels-1:0];
  assign w_wr_bits  = bus.wdata[channels-1:0];
  assign w_off      = {bus.addr[4:2], 2'b00};
  assign w_wr_any   = |bus.we;
  assign w_claim_rd = bus.re && (w_off == INTC_CLAIM);
  assign w_claim_id = intc_claim_id(32'(r_pending & r_enable));

  // A W1C only ever reaches edge channels; the pending mux below enforces that.
  assign w_clr       = ((w_wr_any && (w_off == INTC_PENDING)) ? (w_wr_bits & w_wr_mask) : '0)
                     | w_claim_clr;
  assign w_mode_fall = (w_wr_any && (w_off == INTC_MODE)) ? (r_mode & w_wr_mask & ~w_wr_bits) : '0;

  // One-hot clear for the channel being claimed this cycle.
  always_comb begin
    w_claim_clr = '0;
    for (int i = 0; i < channels; i++) begin
      if (w_claim_rd && (w_claim_id == 32'(i + 1))) begin
        w_claim_clr[i] = 1'b1;
      end else begin
        w_claim_clr[i] = 1'b0;
      end
    end
  end

  // Pending update: level reloads from s, edge sets on a rise (set wins over clear).
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < channels; i++) begin
      if (intc_mode_t'(r_mode[i]) == INTC_EDGE) begin
        if (w_mode_fall[i]) begin
          w_pending_nxt[i] = 1'b0;
        end else if (w_rise[i]) begin
          w_pending_nxt[i] = 1'b1;
        end else if (w_clr[i]) begin
          w_pending_nxt[i] = 1'b0;
        end else begin
          w_pending_nxt[i] = r_pending[i];
        end
      end else begin
        w_pending_nxt[i] = w_s[i];
      end
    end
  end

  // Register read mux; the unused offsets read as zero.
  always_comb begin
    w_rd_data = 32'd0;
    case (w_off)
      INTC_PENDING:  w_rd_data = 32'(r_pending);
      INTC_ENABLE:   w_rd_data = 32'(r_enable);
      INTC_MODE:     w_rd_data = 32'(r_mode);
      INTC_POLARITY: w_rd_data = 32'(r_polarity);
      INTC_CLAIM:    w_rd_data = w_claim_id;
      INTC_RAW:      w_rd_data = 32'(w_raw);
      default:       w_rd_data = 32'd0;
    endcase
  end

  // Register file, pending state and registered interrupt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_enable   <= '0;
      r_mode     <= '0;
      r_polarity <= '0;
      r_irq_out  <= '0;
      r_irq_any  <= 1'b0;
    end else begin
      if (w_wr_any && (w_off == INTC_ENABLE)) begin
        r_enable <= (r_enable & ~w_wr_mask) | (w_wr_bits & w_wr_mask);
      end
      if (w_wr_any && (w_off == INTC_MODE)) begin
        r_mode <= (r_mode & ~w_wr_mask) | (w_wr_bits & w_wr_mask);
      end
      if (w_wr_any && (w_off == INTC_POLARITY)) begin
        r_polarity <= (r_polarity & ~w_wr_mask) | (w_wr_bits & w_wr_mask);
      end
      r_pending <= w_pending_nxt;
      r_irq_out <= r_pending & r_enable;
      r_irq_any <= |(r_pending & r_enable);
    end
  end

  // Bus response: one-cycle ready for every request, rdata only on reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= bus.re | w_wr_any;
      r_rdata <= bus.re ? w_rd_data : 32'd0;
    end
  end

  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;
  assign irq_out   = r_irq_out;
  assign irq_any   = r_irq_any;

endmodule

// File: doc/boa_peri_intc.md
# boa_peri_intc

Parametrised interrupt controller peripheral for the boa32 SoC, sitting on a peripheral-mux port (`boa_mem_bus`) between raw interrupt sources (UART, PMU, GPIO, timers) and the CPU's `irq[31:16]` lines. It replaces hardwired source-to-`irq` assignments with:
- per-channel input synchronisation;
- per-channel level or edge mode and polarity;
- latched pending bits and an enable mask;
- a claim register returning the lowest active channel.

## Interface
Parameters:
- `channels`, 14: number of interrupt channels, 1..32.
- `sync_stages`, 2: synchroniser flops per input, 0..3. 0 bypasses synchronisation for same-clock sources.

Ports:
- `clk`  in  1  CPU clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bus`  `boa_mem_bus.MEM`  —  register port. Uses `addr[31:2]`, `we[3:0]`, `re`, `wdata[31:0]`, `rdata[31:0]`, `ready`.
- `irq_in`  in  `channels`  raw interrupt sources, any clock domain.
- `irq_out`  out  `channels`  registered `pending & enable`, drives CPU `irq[16 +: channels]`.
- `irq_any`  out  1  registered OR of `irq_out`.

## Operation
Registers, decoded on `addr[4:2]`, all `channels` bits wide and zero-extended to 32:
- 0x00 PENDING, R/W1C. Write-1-to-clear affects edge-mode channels only.
- 0x04 ENABLE, RW.
- 0x08 MODE, RW. 0 = level, 1 = edge.
- 0x0C POLARITY, RW. 1 inverts the input: active-low in level mode, falling edge in edge mode.
- 0x10 CLAIM, R. Returns index+1 of the lowest channel with `pending & enable`, or 0 if none. Reading clears that channel's pending bit if it is in edge mode.
- 0x14 RAW, R. Synchronised `irq_in` before polarity.
- Offsets 0x18–0x1C: read 0, writes ignored, still acknowledged.

Write and pending rules:
- Writes honour byte lanes in `we`.
- Let `s` = synchronised input XOR polarity.
- Level channel: the pending bit is reloaded from `s` every cycle.
- Edge channel: the pending bit is set on a 0→1 transition of `s` and held until W1C or claim.

Boundary conditions:
- Set wins: an edge in the same cycle as a W1C or claim of that channel leaves the bit set.
- Writing MODE 1→0 discards the latched bit; the next cycle reloads it from `s`.
- Writing POLARITY can create an edge on `s`; this is counted as a real edge.
- Edge detection is armed from reset with the previous-value flop at 0. An input already active at reset release latches pending, but it stays masked because ENABLE resets to 0.
- Channel bits at or above `channels` read 0 and ignore writes.

## Timing
- Reset (asynchronous assert, release on any edge):
  - all registers, synchroniser and edge flops at 0;
  - `irq_out` = 0, `irq_any` = 0, `bus.ready` = 0, `bus.rdata` = 0.
- Bus:
  - `ready` pulses exactly one cycle after any cycle with `re` or non-zero `we`.
  - `rdata` is valid in that cycle and 0 otherwise.
  - Write effects are visible from the cycle `ready` is high.
  - Back-to-back requests are accepted every cycle, with one cycle of latency each.
- Source latency: `irq_in` change to `irq_out`/`irq_any` change is `sync_stages` + 2 rising edges (synchroniser, pending register, output register).
- ENABLE, W1C or claim to `irq_out` change: 1 cycle after the bus access is sampled.
- Claim arbitration is combinational over the current pending/enable. It is captured into `rdata` and the clear in the same edge.
- Reset asserted mid-transfer: the transaction is abandoned and no `ready` is issued.

## Structure
- Package `boa_intc_pkg`:
  - register offset constants `INTC_PENDING` … `INTC_RAW`;
  - mode enum `intc_mode_t` {`INTC_LEVEL`, `INTC_EDGE`};
  - `channels` upper-bound constant.
- Sub-module `boa_intc_sync_edge`, one instance per channel. Contains the `sync_stages` flop chain, polarity XOR, previous-value flop and rise-pulse output.
- Top level contains:
  - register file;
  - pending logic;
  - priority encoder for CLAIM;
  - bus response register.

## Test plan
- Level mode, polarity 0, ENABLE = 0x1: raise `irq_in[0]` → `irq_out[0]` = 1 after 4 edges. Drop it → 0 after 4 edges. A PENDING W1C of 0x1 has no effect.
- Edge mode on ch 3, 1-cycle pulse on `irq_in[3]` → PENDING reads 0x8 and stays set. Write 0x8 to 0x00 → cleared, `irq_out[3]` = 0 one cycle after `ready`.
- Edge channels 2 and 5 pending and enabled: CLAIM reads 3, then 6, then 0. `irq_any` falls after the second claim.
- Edge arriving on ch 1 in the same cycle as its W1C → PENDING still 0x2.
- POLARITY = 1 with edge mode on ch 0, input idles high and drops → pending set. RAW reads 0.
- Assert `rst_n` low during a read with pending = 0x3 → `ready` never pulses. All registers and outputs read 0 after release.
